dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
Direct-mapped, write-back, write-allocate data cache. It is the responder on the pipeline's D-cache port (data_read/data_write/data_mbe/data_addr/data_wdata → data_resp/data_rdata). It sits between the datapath MEM stage and the line-granular physical memory port. Hits complete in zero wait cycles, so the pipeline stalls only on misses.

Parameters:
S_INDEX, 3, index bits; the cache has 2^S_INDEX sets.
S_OFFSET, 5, line offset bits; a line is 32 bytes = 8 words = 256 bits (fixed).
S_TAG, 32-S_INDEX-S_OFFSET, tag width (derived, not overridable).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
data_read  in  1  load request; held until data_resp.
data_write  in  1  store request; held until data_resp.
data_mbe  in  4  byte enables for stores; ignored on reads.
data_addr  in  32  word-aligned address; bits [1:0] are always 0.
data_wdata  in  32  store data, already lane-shifted.
data_resp  out  1  one-cycle completion strobe.
data_rdata  out  32  full word at data_addr; valid only while data_resp=1.
pmem_read  out  1  line fill request.
pmem_write  out  1  line writeback request.
pmem_addr  out  32  line address, bits [4:0] = 0.
pmem_wdata  out  256  victim line.
pmem_rdata  in  256  fill line.
pmem_resp  in  1  one-cycle memory completion.

Behaviour:
- Address split: tag = data_addr[31:S_INDEX+5]; index = data_addr[S_INDEX+4:5]; word = data_addr[4:2].
- Storage per set: valid, dirty, tag, 256-bit line, all in flops. Reads are combinational.
- Reset (rst=0, async):
  - All valid and dirty bits clear; state = CHECK.
  - data_resp=0, data_rdata=0, pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0.
  - Data and tag arrays are not reset.
  - Reset mid-miss abandons the memory transaction; a pmem_resp that arrives later is ignored.
- State CHECK:
  - No request: all outputs 0.
  - Hit (request, valid[index], tag match): data_resp=1 combinationally in the same cycle; data_rdata = line[word].
    - Read: no state change.
    - Write: at that clock edge, merge byte k of data_wdata into line[word] for each data_mbe[k]=1, and set dirty.
    - data_mbe=0000 on a write hit: respond, leave data unchanged, still set dirty.
  - Miss with valid & dirty: go to WRITEBACK. Miss otherwise: go to ALLOCATE. data_resp stays 0.
- State WRITEBACK:
  - pmem_write=1; pmem_addr = {stored tag, index, 5'b0}; pmem_wdata = stored line.
  - These stay stable until pmem_resp=1, then go to ALLOCATE.
- State ALLOCATE:
  - pmem_read=1; pmem_addr = {req tag, index, 5'b0}.
  - On pmem_resp=1: write pmem_rdata into the line, set tag, valid=1, dirty=0, return to CHECK.
  - The held request then hits in the next cycle, so miss latency = memory cycles + 1.
- pmem_read and pmem_write are never high together.
- Outside WRITEBACK, pmem_wdata=0. Outside WRITEBACK/ALLOCATE, pmem_addr=0.
- data_read and data_write high together: write wins; a simulation assertion flags it.
- Request withdrawn during a miss: the FSM still completes the memory transaction, returns to CHECK, and issues no data_resp.
- Request held after its data_resp edge: treated as a new access (the pipeline has advanced).
- The FSM never idles between back-to-back hits; one hit per cycle is sustained.

Test Plan:
- Cold read 0x0000_1004: one pmem_read at 0x0000_1000; memory returns a line with word1=0xDEADBEEF; data_resp one cycle after pmem_resp with rdata=0xDEADBEEF. Immediate reread of 0x1004 → data_resp same cycle, no pmem traffic.
- Write hit with partial byte enables:
  - Step 1: write 0x1004, mbe=0011, wdata=0x0000_1234 → data_resp same cycle.
  - Step 2: read 0x1004 → 0xDEAD1234.
- Dirty eviction (S_INDEX=3): after the step above, read 0x0000_1104 (same index 0, different tag).
  - pmem_write first: addr 0x1000, wdata word1=0xDEAD1234.
  - Then pmem_read at 0x1100.
  - Then data_resp.
- Clean eviction: read 0x2000 then 0x2100 with no writes between → only pmem_read is issued, never pmem_write.
- Reset mid-ALLOCATE:
  - Assert rst=0 while pmem_read=1 → pmem_read=0 and data_resp=0 immediately.
  - After release, reread the prior hit address → miss (valid cleared).
- Back-to-back hits to 8 words of one line, alternating read/write → 8 consecutive data_resp cycles with correct merged data, no pmem activity.

Source files
------------

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache with zero-wait hits
// Ports: clk/rst (async active-low); data_* is the pipeline request/response port
// (held request, one-cycle data_resp); pmem_* is the line-granular memory port
// (pmem_read fills, pmem_write evicts, pmem_resp one-cycle completion).
module dcache_responder #(
    parameter int S_INDEX = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_read,
    input  logic         data_write,
    input  logic [3:0]   data_mbe,
    input  logic [31:0]  data_addr,
    input  logic [31:0]  data_wdata,
    output logic         data_resp,
    output logic [31:0]  data_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_addr,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
    localparam int SETS = 1 << S_INDEX;
    localparam int LINE_W = 32 - S_OFFSET;
    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;
    state_t state, state_n;
    logic [SETS-1:0] valid, dirty;
    logic [S_TAG-1:0] tags [SETS];
    logic [255:0] lines [SETS];
    logic [LINE_W-1:0] miss_line;
    logic [S_TAG-1:0] req_tag, miss_tag;
    logic [S_INDEX-1:0] req_idx, miss_idx;
    logic [2:0] word;
    logic req, hit, miss;
    logic [31:0] cur_word, merged;
    logic [255:0] upd_line;
    assign req_tag = data_addr[31 -: S_TAG];
    assign req_idx = data_addr[S_OFFSET +: S_INDEX];
    assign word = data_addr[4:2];
    // the missing line is latched so a withdrawn request cannot redirect the fill
    assign miss_tag = miss_line[LINE_W-1 -: S_TAG];
    assign miss_idx = miss_line[S_INDEX-1:0];
    assign req = data_read | data_write;
    assign hit = state == CHECK && req && valid[req_idx] && tags[req_idx] == req_tag;
    assign miss = state == CHECK && req && !hit;
    assign cur_word = lines[req_idx][word*32 +: 32];
    always_comb begin
        merged = cur_word;
        for (int k = 0; k < 4; k++)
            merged[k*8 +: 8] = data_mbe[k] ? data_wdata[k*8 +: 8] : cur_word[k*8 +: 8];
        upd_line = lines[req_idx];
        upd_line[word*32 +: 32] = merged;
    end
    always_comb begin
        state_n = state;
        data_resp = hit;
        data_rdata = hit ? cur_word : '0;
        pmem_read = state == ALLOCATE;
        pmem_write = state == WRITEBACK;
        pmem_addr = '0;
        pmem_wdata = '0;
        case (state)
            CHECK: state_n = miss ? (valid[req_idx] && dirty[req_idx] ? WRITEBACK : ALLOCATE) : CHECK;
            WRITEBACK: begin
                pmem_addr = {tags[miss_idx], miss_idx, {S_OFFSET{1'b0}}};
                pmem_wdata = lines[miss_idx];
                state_n = pmem_resp ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                pmem_addr = {miss_line, {S_OFFSET{1'b0}}};
                state_n = pmem_resp ? CHECK : ALLOCATE;
            end
            default: state_n = CHECK;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CHECK;
            valid <= '0;
            dirty <= '0;
            miss_line <= '0;
        end else begin
            state <= state_n;
            if (miss)
                miss_line <= data_addr[31:S_OFFSET];
            if (hit && data_write)
                dirty[req_idx] <= 1'b1;
            if (state == ALLOCATE && pmem_resp) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (hit && data_write)
            lines[req_idx] <= upd_line;
        else if (state == ALLOCATE && pmem_resp) begin
            lines[miss_idx] <= pmem_rdata;
            tags[miss_idx] <= miss_tag;
        end
    end
    // write wins when both strobes are high; addresses must be word aligned
    a_req_legal: assert property (@(posedge clk) disable iff (!rst)
        !(data_read && data_write) && data_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed and random accesses checked against a flat-memory reference
module tb_dcache_responder;
    logic clk = 0, rst;
    logic data_read, data_write, data_resp, pmem_read, pmem_write, pmem_resp;
    logic [3:0] data_mbe;
    logic [31:0] data_addr, data_wdata, data_rdata, pmem_addr;
    logic [255:0] pmem_wdata, pmem_rdata;
    dcache_responder dut (
        .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
        .data_mbe(data_mbe), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );
    always #5 clk = ~clk;
    int errs = 0, checks = 0;
    int mem_lat = 0, wait_cnt = 0, rd_cnt = 0, wb_cnt = 0, first_ev = 0;
    logic [31:0] rd_addr, wb_addr;
    logic [255:0] wb_data;
    logic [255:0] gm [logic [26:0]];
    logic [255:0] bmem [logic [26:0]];
    logic rv [8];
    logic rdy [8];
    logic [26:0] rl [8];
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [255:0] init_line(input logic [26:0] l);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = ({l, 5'b0} + 32'(i * 4)) ^ 32'h5A5A_0000;
        return r;
    endfunction
    function automatic logic [255:0] gm_get(input logic [26:0] l);
        return gm.exists(l) ? gm[l] : init_line(l);
    endfunction
    function automatic logic [255:0] bm_get(input logic [26:0] l);
        return bmem.exists(l) ? bmem[l] : init_line(l);
    endfunction
    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            rv[i] = 0;
            rdy[i] = 0;
            rl[i] = '0;
        end
        gm = bmem;
    endfunction
    // memory: answers each pmem request after mem_lat idle cycles
    initial begin
        pmem_resp = 0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 0;
            if (!(pmem_read || pmem_write)) wait_cnt = mem_lat;
            else if (wait_cnt > 0) wait_cnt--;
            else begin
                chk("pmem_excl", pmem_read && pmem_write, 0);
                chk("pmem_align", pmem_addr[4:0], 0);
                if (pmem_write) begin
                    wb_cnt++;
                    wb_addr = pmem_addr;
                    wb_data = pmem_wdata;
                    if (first_ev == 0) first_ev = 1;
                    chk("wb_data", pmem_wdata, gm_get(pmem_addr[31:5]));
                    bmem[pmem_addr[31:5]] = pmem_wdata;
                end else begin
                    rd_cnt++;
                    rd_addr = pmem_addr;
                    if (first_ev == 0) first_ev = 2;
                    pmem_rdata = bm_get(pmem_addr[31:5]);
                end
                pmem_resp = 1;
                wait_cnt = mem_lat;
            end
        end
    end
    task automatic access(input logic wr, input logic [31:0] a, input logic [3:0] mbe,
                          input logic [31:0] wd, input string tag, output int cyc);
        logic [26:0] l = a[31:5];
        int s = int'(a[7:5]);
        int w = int'(a[4:2]);
        logic exp_hit = rv[s] && rl[s] == l;
        logic exp_wb = !exp_hit && rv[s] && rdy[s];
        logic [26:0] victim = rl[s];
        logic [255:0] line = gm_get(l);
        logic [31:0] exp_word = line[w*32 +: 32];
        @(negedge clk);
        rd_cnt = 0;
        wb_cnt = 0;
        first_ev = 0;
        data_read = !wr;
        data_write = wr;
        data_addr = a;
        data_mbe = mbe;
        data_wdata = wd;
        cyc = 0;
        #1;
        while (!data_resp && cyc < 200) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        chk({tag, "_resp"}, data_resp, 1);
        if (!wr) chk({tag, "_rdata"}, data_rdata, exp_word);
        chk({tag, "_wbcnt"}, wb_cnt, exp_wb);
        chk({tag, "_rdcnt"}, rd_cnt, !exp_hit);
        if (exp_hit) chk({tag, "_hitlat"}, cyc, 0);
        if (exp_wb) begin
            chk({tag, "_wbaddr"}, wb_addr, {victim, 5'b0});
            chk({tag, "_order"}, first_ev, 1);
        end
        if (!exp_hit) chk({tag, "_rdaddr"}, rd_addr, {l, 5'b0});
        if (!exp_hit) begin
            rv[s] = 1;
            rl[s] = l;
            rdy[s] = 0;
        end
        if (wr) begin
            for (int k = 0; k < 4; k++)
                if (mbe[k]) line[w*32 + k*8 +: 8] = wd[k*8 +: 8];
            rdy[s] = 1;
        end
        gm[l] = line;
    endtask
    task automatic idle();
        @(negedge clk);
        data_read = 0;
        data_write = 0;
    endtask
    initial begin
        int cyc, n;
        logic [26:0] l;
        logic [255:0] ln;
        rst = 1;
        data_read = 0;
        data_write = 0;
        data_mbe = '0;
        data_addr = '0;
        data_wdata = '0;
        model_reset();
        #2 rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp", data_resp, 0);
        chk("rst_rdata", data_rdata, 0);
        chk("rst_pread", pmem_read, 0);
        chk("rst_pwrite", pmem_write, 0);
        chk("rst_paddr", pmem_addr, 0);
        chk("rst_pwdata", pmem_wdata, 0);
        @(negedge clk) rst = 1;
        l = 27'h80;
        ln = init_line(l);
        ln[63:32] = 32'hDEADBEEF;
        bmem[l] = ln;
        gm[l] = ln;
        access(0, 32'h1004, 4'h0, 0, "cold", cyc);
        chk("cold_lat", cyc, 2);
        chk("cold_val", data_rdata, 32'hDEADBEEF);
        access(0, 32'h1004, 4'h0, 0, "reread", cyc);
        access(1, 32'h1004, 4'b0011, 32'h0000_1234, "wr_part", cyc);
        access(0, 32'h1004, 4'h0, 0, "rd_merge", cyc);
        chk("merge_val", data_rdata, 32'hDEAD1234);
        access(0, 32'h1104, 4'h0, 0, "evict", cyc);
        chk("evict_lat", cyc, 3);
        chk("evict_word", wb_data[63:32], 32'hDEAD1234);
        idle();
        access(0, 32'h2000, 4'h0, 0, "clean_a", cyc);
        access(0, 32'h2100, 4'h0, 0, "clean_b", cyc);
        chk("clean_nowb", wb_cnt, 0);
        access(1, 32'h2104, 4'h0, 32'hFFFF_FFFF, "wr_mbe0", cyc);
        access(0, 32'h2104, 4'h0, 0, "rd_mbe0", cyc);
        access(0, 32'h2004, 4'h0, 0, "evict_mbe0", cyc);
        chk("mbe0_dirty", wb_cnt, 1);
        access(0, 32'h3000, 4'h0, 0, "b2b_fill", cyc);
        for (int i = 0; i < 8; i++)
            access(i % 2 == 0, 32'h3000 + 32'(i * 4), 4'($urandom), $urandom, "b2b", cyc);
        for (int i = 0; i < 8; i++)
            access(0, 32'h3000 + 32'(i * 4), 4'h0, 0, "b2b_rd", cyc);
        idle();
        mem_lat = 5;
        @(negedge clk);
        data_read = 1;
        data_addr = 32'h4000;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_alloc_seen", pmem_read, 1);
        rst = 0;
        #1;
        chk("mid_rst_pread", pmem_read, 0);
        chk("mid_rst_resp", data_resp, 0);
        chk("mid_rst_paddr", pmem_addr, 0);
        data_read = 0;
        model_reset();
        @(negedge clk) rst = 1;
        mem_lat = 0;
        access(0, 32'h3004, 4'h0, 0, "post_rst", cyc);
        chk("post_rst_miss", rd_cnt, 1);
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = 32'h0001_0000 | 32'($urandom_range(0, 3)) << 8 | 32'($urandom_range(0, 7)) << 5
                | 32'($urandom_range(0, 7)) << 2;
            mem_lat = $urandom_range(0, 3);
            access(1'($urandom), a, 4'($urandom), $urandom, "rnd", cyc);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
